pc_gen: RTL and testbench

Parametrised fetch program-counter generator for the toy RISC-V core. It sits between the execute stage and instruction memory and holds the architectural fetch PC. Each cycle it selects the next PC from trap, branch/JAL/JALR redirect, return-address-stack prediction or sequential increment. It presents the PC to instruction memory through a valid/ready handshake and supports optional 16-bit instruction steps, halt/resume, and target-misalignment reporting.

---
 rtl/pc_gen.sv | 171 +++++++++++++++++
 tb/tb_pc_gen.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// pc_gen: fetch program-counter generator for the toy RISC-V core.
//
// Holds the architectural fetch PC and picks the next one each cycle from
// (highest first) trap, execute redirect, return-address-stack prediction
// or the sequential step. The PC goes to instruction memory through a
// valid/ready handshake.
//
// Ports
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   fetch_valid_o/fetch_ready_i
//                              fetch handshake, pc_o is the request
//   pc_o                       registered fetch PC
//   stall_i                    blocks issue only, never redirects
//   take_branch_i, is_jalr_i,
//   branch_target_i, alu_result_i
//                              execute-stage redirect
//   trap_i, trap_vector_i      trap redirect
//   inst_len2_i                fired instruction is 16-bit
//   pred_ret_i                 fired instruction predecoded as return
//   ras_push_i, ras_push_addr_i
//                              push a resolved return address
//   halt_i, resume_i           enter / leave HALT
//   misaligned_o, bad_addr_o   one-cycle report of a rejected redirect target
// -----------------------------------------------------------------------------
module pc_gen #(
    parameter int unsigned        width_p         = 32,
    parameter logic [width_p-1:0] reset_vector_p  = '0,
    parameter int unsigned        ras_depth_p     = 4,
    parameter bit                 compressed_en_p = 1'b0
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    output logic               fetch_valid_o,
    input  logic               fetch_ready_i,
    output logic [width_p-1:0] pc_o,
    input  logic               stall_i,
    input  logic               take_branch_i,
    input  logic               is_jalr_i,
    input  logic [width_p-1:0] branch_target_i,
    input  logic [width_p-1:0] alu_result_i,
    input  logic               trap_i,
    input  logic [width_p-1:0] trap_vector_i,
    input  logic               inst_len2_i,
    input  logic               pred_ret_i,
    input  logic               ras_push_i,
    input  logic [width_p-1:0] ras_push_addr_i,
    input  logic               halt_i,
    input  logic               resume_i,
    output logic               misaligned_o,
    output logic [width_p-1:0] bad_addr_o
);

    localparam int unsigned ptr_w = $clog2(ras_depth_p);
    localparam int unsigned cnt_w = ptr_w + 1;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [width_p-1:0] pc_d;
    logic [width_p-1:0] target;
    logic [width_p-1:0] step_size;
    logic               target_bad;
    logic               fire;
    logic               trap_act;
    logic               br_act;
    logic               pop;
    logic               push;

    logic [width_p-1:0] ras_q [ras_depth_p];
    logic [ptr_w-1:0]   ras_ptr_q;    // next free slot; top is ras_ptr_q - 1
    logic [cnt_w-1:0]   ras_cnt_q;
    logic [width_p-1:0] ras_top;

    assign fetch_valid_o = (state_q == RUN) & ~stall_i;
    assign fire          = fetch_valid_o & fetch_ready_i;

    // JALR clears bit 0 of the sum; bit 1 is only legal with 16-bit steps.
    assign target     = is_jalr_i ? (alu_result_i & {{(width_p-1){1'b1}}, 1'b0})
                                  : branch_target_i;
    assign target_bad = target[0] | (!compressed_en_p && target[1]);

    // Trap is honoured in RUN and HALT; redirects only in RUN.
    assign trap_act = trap_i & ((state_q == RUN) | (state_q == HALT));
    assign br_act   = take_branch_i & ~trap_i & (state_q == RUN);

    assign ras_top  = ras_q[ras_ptr_q - ptr_w'(1)];
    assign pop      = fire & ~trap_i & ~take_branch_i & pred_ret_i & (ras_cnt_q != '0);
    assign push     = ras_push_i & ~trap_act;

    assign step_size = (compressed_en_p && inst_len2_i) ? width_p'(2) : width_p'(4);

    // ---------------- FSM ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT:    state_d = RUN;
            RUN:     if (halt_i && !trap_i && !take_branch_i) state_d = HALT;
            HALT:    if (resume_i || trap_i) state_d = RUN;
            default: state_d = BOOT;
        endcase
    end

    // ---------------- next-PC selection ----------------
    always_comb begin
        pc_d = pc_o;
        if (trap_act) begin
            pc_d = trap_vector_i;
        end else if (br_act) begin
            // A rejected target leaves the PC where it is.
            if (!target_bad) pc_d = target;
        end else if (pop) begin
            pc_d = ras_top;
        end else if (fire) begin
            pc_d = pc_o + step_size;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_o         <= reset_vector_p;
            misaligned_o <= 1'b0;
            bad_addr_o   <= '0;
        end else begin
            pc_o         <= pc_d;
            misaligned_o <= br_act & target_bad;
            if (br_act && target_bad) bad_addr_o <= target;
        end
    end

    // ---------------- return-address stack ----------------
    // Entries carry no reset; an empty stack is defined purely by the count.
    always_ff @(posedge clk_i) begin
        if (push) begin
            // Push with pop replaces the top in place.
            if (pop) ras_q[ras_ptr_q - ptr_w'(1)] <= ras_push_addr_i;
            else     ras_q[ras_ptr_q]              <= ras_push_addr_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ras_ptr_q <= '0;
            ras_cnt_q <= '0;
        end else if (trap_act) begin
            ras_cnt_q <= '0;
        end else if (push && !pop) begin
            // Full stack: the pointer wraps over the oldest entry, count saturates.
            ras_ptr_q <= ras_ptr_q + ptr_w'(1);
            if (ras_cnt_q != cnt_w'(ras_depth_p)) ras_cnt_q <= ras_cnt_q + cnt_w'(1);
        end else if (pop && !push) begin
            ras_ptr_q <= ras_ptr_q - ptr_w'(1);
            ras_cnt_q <= ras_cnt_q - cnt_w'(1);
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
`timescale 1ns/1ps
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ready = 1'b1;
    logic        stall = 1'b0;
    logic        take_branch = 1'b0;
    logic        is_jalr = 1'b0;
    logic [31:0] branch_target = '0;
    logic [31:0] alu_result = '0;
    logic        trap = 1'b0;
    logic [31:0] trap_vector = '0;
    logic        inst_len2 = 1'b0;
    logic        pred_ret = 1'b0;
    logic        ras_push = 1'b0;
    logic [31:0] ras_push_addr = '0;
    logic        halt = 1'b0;
    logic        resume = 1'b0;

    logic        valid0, valid1, mis0, mis1;
    logic [31:0] pc0, pc1, bad0, bad1;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp0_q[$];
    logic [31:0] exp1_q[$];
    logic [31:0] mis0_q[$];
    logic [31:0] mis1_q[$];

    always #5 clk = ~clk;

    pc_gen #(.width_p(32), .reset_vector_p(32'h100), .ras_depth_p(4), .compressed_en_p(1'b0)) u_c0 (
        .clk_i(clk), .rst_ni(rst_n), .fetch_valid_o(valid0), .fetch_ready_i(ready), .pc_o(pc0),
        .stall_i(stall), .take_branch_i(take_branch), .is_jalr_i(is_jalr),
        .branch_target_i(branch_target), .alu_result_i(alu_result), .trap_i(trap),
        .trap_vector_i(trap_vector), .inst_len2_i(inst_len2), .pred_ret_i(pred_ret),
        .ras_push_i(ras_push), .ras_push_addr_i(ras_push_addr), .halt_i(halt),
        .resume_i(resume), .misaligned_o(mis0), .bad_addr_o(bad0)
    );

    pc_gen #(.width_p(32), .reset_vector_p(32'h100), .ras_depth_p(4), .compressed_en_p(1'b1)) u_c1 (
        .clk_i(clk), .rst_ni(rst_n), .fetch_valid_o(valid1), .fetch_ready_i(ready), .pc_o(pc1),
        .stall_i(stall), .take_branch_i(take_branch), .is_jalr_i(is_jalr),
        .branch_target_i(branch_target), .alu_result_i(alu_result), .trap_i(trap),
        .trap_vector_i(trap_vector), .inst_len2_i(inst_len2), .pred_ret_i(pred_ret),
        .ras_push_i(ras_push), .ras_push_addr_i(ras_push_addr), .halt_i(halt),
        .resume_i(resume), .misaligned_o(mis1), .bad_addr_o(bad1)
    );

    // ---------------- monitors: pop expectations when the DUT presents output ----
    always @(negedge clk) begin
        if (valid0 === 1'b1 && ready === 1'b1) begin
            total++;
            if (exp0_q.size() == 0) begin
                bad++;
                $display("FAIL fetch_c0: unexpected fetch pc=%h", pc0);
            end else begin
                logic [31:0] e;
                e = exp0_q.pop_front();
                if (pc0 !== e) begin
                    bad++;
                    $display("FAIL fetch_c0: got pc=%h want %h", pc0, e);
                end
            end
        end
        if (valid1 === 1'b1 && ready === 1'b1) begin
            total++;
            if (exp1_q.size() == 0) begin
                bad++;
                $display("FAIL fetch_c1: unexpected fetch pc=%h", pc1);
            end else begin
                logic [31:0] e;
                e = exp1_q.pop_front();
                if (pc1 !== e) begin
                    bad++;
                    $display("FAIL fetch_c1: got pc=%h want %h", pc1, e);
                end
            end
        end
        if (mis0 === 1'b1) begin
            total++;
            if (mis0_q.size() == 0) begin
                bad++;
                $display("FAIL misalign_c0: unexpected pulse bad_addr=%h", bad0);
            end else begin
                logic [31:0] e;
                e = mis0_q.pop_front();
                if (bad0 !== e) begin
                    bad++;
                    $display("FAIL misalign_c0: got bad_addr=%h want %h", bad0, e);
                end
            end
        end
        if (mis1 === 1'b1) begin
            total++;
            if (mis1_q.size() == 0) begin
                bad++;
                $display("FAIL misalign_c1: unexpected pulse bad_addr=%h", bad1);
            end else begin
                logic [31:0] e;
                e = mis1_q.pop_front();
                if (bad1 !== e) begin
                    bad++;
                    $display("FAIL misalign_c1: got bad_addr=%h want %h", bad1, e);
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic expect_fire(input logic [31:0] e0, input logic [31:0] e1);
        exp0_q.push_back(e0);
        exp1_q.push_back(e1);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        // Reset state
        step(); step();
        chk("reset_pc", pc0, 32'h100);
        chk("reset_valid", {31'd0, valid0}, 32'd0);
        chk("reset_mis", {31'd0, mis0}, 32'd0);
        chk("reset_bad_addr", bad0, 32'd0);

        // Reset release: BOOT for one cycle, then sequential fetch
        expect_fire(32'h100, 32'h100);
        expect_fire(32'h104, 32'h104);
        expect_fire(32'h108, 32'h108);
        rst_n = 1'b1;
        chk("boot_valid_low", {31'd0, valid0}, 32'd0);
        step();
        chk("run_valid_high", {31'd0, valid0}, 32'd1);
        step(); step(); step();
        ready = 1'b0;

        // Back-pressure then stall
        step(); step(); step();
        chk("backpressure_pc", pc0, 32'h10C);
        stall = 1'b1;
        ready = 1'b1;
        #1;
        chk("stall_valid", {31'd0, valid0}, 32'd0);
        step(); step();
        chk("stall_pc", pc0, 32'h10C);
        stall = 1'b0;
        expect_fire(32'h10C, 32'h10C);
        expect_fire(32'h110, 32'h110);
        step(); step();
        ready = 1'b0;
        chk("after_stall_pc", pc0, 32'h114);

        // Priority: trap beats branch and RAS return, and flushes the RAS
        ras_push = 1'b1; ras_push_addr = 32'h500;
        step();
        ras_push = 1'b0;
        trap = 1'b1; trap_vector = 32'h80;
        take_branch = 1'b1; branch_target = 32'h300;
        pred_ret = 1'b1; ready = 1'b1;
        expect_fire(32'h114, 32'h114);
        step();
        trap = 1'b0; take_branch = 1'b0;
        chk("trap_pc", pc0, 32'h80);
        expect_fire(32'h80, 32'h80);
        step();
        pred_ret = 1'b0; ready = 1'b0;
        chk("ras_flushed_pc", pc0, 32'h84);

        // JALR: 0x203 -> 0x202, legal only with compressed steps
        take_branch = 1'b1; is_jalr = 1'b1; alu_result = 32'h203;
        mis0_q.push_back(32'h202);
        step();
        take_branch = 1'b0; is_jalr = 1'b0;
        chk("jalr_c0_held", pc0, 32'h84);
        chk("jalr_c1_pc", pc1, 32'h202);
        step();
        chk("mis_one_cycle", {31'd0, mis0}, 32'd0);
        // bit 0 set is rejected in both configurations
        take_branch = 1'b1; branch_target = 32'h401;
        mis0_q.push_back(32'h401);
        mis1_q.push_back(32'h401);
        step();
        take_branch = 1'b0;
        step();
        chk("odd_c0_held", pc0, 32'h84);
        chk("odd_c1_held", pc1, 32'h202);
        take_branch = 1'b1; branch_target = 32'h400;
        step();
        take_branch = 1'b0;
        chk("branch_c0", pc0, 32'h400);
        chk("branch_c1", pc1, 32'h400);

        // RAS: overflow of a depth-4 stack, then five returns
        for (int i = 1; i <= 5; i++) begin
            ras_push = 1'b1; ras_push_addr = 32'(i) << 4;
            step();
        end
        ras_push = 1'b0;
        ready = 1'b1; pred_ret = 1'b1;
        expect_fire(32'h400, 32'h400);
        expect_fire(32'h50, 32'h50);
        expect_fire(32'h40, 32'h40);
        expect_fire(32'h30, 32'h30);
        expect_fire(32'h20, 32'h20);
        step(); step(); step(); step(); step();
        ready = 1'b0; pred_ret = 1'b0;
        chk("ras_fallback_pc", pc0, 32'h24);
        // Push and pop in the same cycle
        ras_push = 1'b1; ras_push_addr = 32'h60;
        step();
        ras_push_addr = 32'h99; ready = 1'b1; pred_ret = 1'b1;
        expect_fire(32'h24, 32'h24);
        step();
        ras_push = 1'b0;
        chk("pushpop_pc", pc0, 32'h60);
        expect_fire(32'h60, 32'h60);
        expect_fire(32'h99, 32'h99);
        step(); step();
        ready = 1'b0; pred_ret = 1'b0;
        chk("pushpop_count_pc", pc0, 32'h9D);

        // Halt: no fetch, branch ignored, trap restarts
        halt = 1'b1;
        step();
        halt = 1'b0; ready = 1'b1;
        #1;
        chk("halt_valid", {31'd0, valid0}, 32'd0);
        take_branch = 1'b1; branch_target = 32'h400;
        step();
        take_branch = 1'b0;
        chk("halt_branch_ignored", pc0, 32'h9D);
        trap = 1'b1; trap_vector = 32'h200;
        step();
        trap = 1'b0; inst_len2 = 1'b1;
        expect_fire(32'h200, 32'h200);
        expect_fire(32'h204, 32'h202);
        chk("halt_trap_valid", {31'd0, valid0}, 32'd1);
        step(); step();
        inst_len2 = 1'b0; ready = 1'b0;
        chk("len2_c0_pc", pc0, 32'h208);
        chk("len2_c1_pc", pc1, 32'h204);
        halt = 1'b1;
        step();
        halt = 1'b0;
        chk("halt2_valid", {31'd0, valid0}, 32'd0);
        resume = 1'b1;
        step();
        resume = 1'b0;
        chk("resume_valid", {31'd0, valid0}, 32'd1);
        chk("resume_pc", pc0, 32'h208);

        // Asynchronous reset mid-operation clears a pending misalign pulse and the RAS
        ras_push = 1'b1; ras_push_addr = 32'h70;
        step();
        ras_push = 1'b0;
        take_branch = 1'b1; branch_target = 32'h203;
        step();
        take_branch = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        chk("midreset_mis", {31'd0, mis0}, 32'd0);
        chk("midreset_pc", pc0, 32'h100);
        chk("midreset_valid", {31'd0, valid0}, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        ready = 1'b1; pred_ret = 1'b1;
        expect_fire(32'h100, 32'h100);
        step();
        ready = 1'b0; pred_ret = 1'b0;
        chk("midreset_ras_empty", pc0, 32'h104);

        step(); step();
        chk("fetch_c0_drained", 32'(exp0_q.size()), 32'd0);
        chk("fetch_c1_drained", 32'(exp1_q.size()), 32'd0);
        chk("mis_c0_drained", 32'(mis0_q.size()), 32'd0);
        chk("mis_c1_drained", 32'(mis1_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
